// File: rtl/stim_source_if.sv
// Complex-sample stream bundle: SAMP_PER_CLK signed re/im pairs per beat plus valid/ready framing.
interface alpaca_data_pkt_axis #(
   parameter int SAMP_PER_CLK = 2,
   parameter int BITS         = 8
);
   typedef struct packed {
      logic signed [BITS-1:0] re;
      logic signed [BITS-1:0] im;
   } cx_t;

   cx_t [SAMP_PER_CLK-1:0] tdata;
   logic                   tvalid;
   logic                   tready;
   logic                   tlast;
   logic [0:0]             tuser;

   modport MST (output tdata, tvalid, tlast, tuser, input tready);
   modport SLV (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/stim_source.sv
// Test-pattern generator (tone / ramp / impulse / zero) with frame markers; one registered output stage,
// beat presented one clock after a load, held stable while the sink stalls.
module stim_source #(
   parameter int SAMP_PER_CLK = 2,
   parameter int BITS         = 8,
   parameter int PHASE_W      = 32,
   parameter int LUT_AW       = 10,
   parameter int FRAME_LEN    = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [1:0]         mode,
   input  logic [PHASE_W-1:0] phase_inc,
   input  logic               restart,
   alpaca_data_pkt_axis.MST   m_axis
);
   localparam int LUT_SZ = 2**LUT_AW;
   localparam int FW     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int DW     = SAMP_PER_CLK*2*BITS;
   localparam logic [BITS-1:0] PEAK = {1'b0, {(BITS-1){1'b1}}};

   function automatic int lut_val(input int i);
      real a;
      a = (2.0**(BITS-1) - 1.0) * $cos(2.0*3.14159265358979323846*real'(i) / real'(LUT_SZ));
      return (a >= 0.0) ? $rtoi(a + 0.5) : -$rtoi(0.5 - a);
   endfunction

   logic [BITS-1:0] w_lut [LUT_SZ];
   for (genvar i = 0; i < LUT_SZ; i++) begin : g_lut
      assign w_lut[i] = BITS'(lut_val(i));
   end

   logic               r_vld;
   logic               r_last;
   logic               r_user;
   logic [DW-1:0]      r_dat;
   logic [PHASE_W-1:0] r_acc;
   logic [BITS-1:0]    r_n;
   logic [FW-1:0]      r_fcnt;
   logic               r_pend;

   logic               w_load;
   logic               w_clr;
   logic [PHASE_W-1:0] w_acc_b;
   logic [BITS-1:0]    w_n_b;
   logic [FW-1:0]      w_f_b;
   logic               w_f_last;
   logic [DW-1:0]      w_beat;

   assign w_load   = en & (~r_vld | m_axis.tready);
   // A restart (fresh or pending) makes the loaded beat start from the zero state.
   assign w_clr    = restart | r_pend;
   assign w_acc_b  = w_clr ? '0 : r_acc;
   assign w_n_b    = w_clr ? '0 : r_n;
   assign w_f_b    = w_clr ? '0 : r_fcnt;
   assign w_f_last = (w_f_b == FW'(FRAME_LEN-1));

   for (genvar k = 0; k < SAMP_PER_CLK; k++) begin : g_samp
      logic [LUT_AW-1:0] w_addr;
      logic [LUT_AW-1:0] w_addr_q;
      logic [BITS-1:0]   w_ramp;
      logic [BITS-1:0]   w_re;
      logic [BITS-1:0]   w_im;

      assign w_addr   = LUT_AW'((w_acc_b + PHASE_W'(k) * phase_inc) >> (PHASE_W - LUT_AW));
      assign w_addr_q = w_addr - LUT_AW'(LUT_SZ/4);
      assign w_ramp   = w_n_b + BITS'(k);

      always_comb begin
         w_re = '0;
         w_im = '0;
         unique case (mode)
            2'd0: begin
               w_re = w_lut[w_addr];
               w_im = w_lut[w_addr_q];
            end
            2'd1: begin
               w_re = w_ramp;
               w_im = ~w_ramp;
            end
            2'd2: if (k == 0 && w_f_b == '0) w_re = PEAK;
            default: ;
         endcase
      end

      assign w_beat[k*2*BITS +: 2*BITS] = {w_re, w_im};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld  <= 1'b0;
         r_last <= 1'b0;
         r_user <= 1'b0;
         r_dat  <= '0;
         r_acc  <= '0;
         r_n    <= '0;
         r_fcnt <= '0;
         r_pend <= 1'b0;
      end else if (w_load) begin
         r_vld  <= 1'b1;
         r_last <= w_f_last;
         r_user <= (w_f_b == '0);
         r_dat  <= w_beat;
         r_acc  <= w_acc_b + PHASE_W'(SAMP_PER_CLK) * phase_inc;
         r_n    <= w_n_b + BITS'(SAMP_PER_CLK);
         r_fcnt <= w_f_last ? '0 : w_f_b + 1'b1;
         r_pend <= 1'b0;
      end else begin
         if (restart) r_pend <= 1'b1;
         if (!en && m_axis.tready && r_vld) r_vld <= 1'b0;
      end
   end

   assign m_axis.tvalid = r_vld;
   assign m_axis.tlast  = r_last;
   assign m_axis.tuser  = r_user;
   assign m_axis.tdata  = r_dat;
endmodule

// File: tb/tb_stim_source.sv
// Randomized self-checking bench for stim_source against a sample-index-level reference model.
module tb_stim_source;
   localparam int  SPC = 2;
   localparam int  B   = 8;
   localparam int  PW  = 32;
   localparam int  LAW = 10;
   localparam int  FL  = 4;
   localparam real PI  = 3.14159265358979323846;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [1:0]  mode;
   logic [31:0] phase_inc;
   logic        restart;
   logic        rdy;
   logic        en1;
   logic [1:0]  mode1;
   logic [31:0] pinc1;
   logic        restart1;

   always #5 clk = ~clk;

   alpaca_data_pkt_axis #(.SAMP_PER_CLK(SPC), .BITS(B)) ax  ();
   alpaca_data_pkt_axis #(.SAMP_PER_CLK(1),   .BITS(B)) ax1 ();
   assign ax.tready  = rdy;
   assign ax1.tready = 1'b1;

   stim_source #(.SAMP_PER_CLK(SPC), .BITS(B), .PHASE_W(PW), .LUT_AW(LAW), .FRAME_LEN(FL)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .phase_inc(phase_inc),
      .restart(restart), .m_axis(ax));

   stim_source #(.SAMP_PER_CLK(1), .BITS(B), .PHASE_W(PW), .LUT_AW(LAW), .FRAME_LEN(1)) dut1 (
      .clk(clk), .rst(rst), .en(en1), .mode(mode1), .phase_inc(pinc1),
      .restart(restart1), .m_axis(ax1));

   int n_chk  = 0;
   int n_fail = 0;

   // Reference state: sample index and beat count since the last reset/restart.
   bit          m_vld, m_last, m_user, m_pend;
   logic [31:0] m_dat;
   bit   [31:0] m_acc;
   int          m_n, m_beat;
   bit          m1_vld;
   logic [15:0] m1_dat;
   int          m1_n;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int rnd127(input real x);
      real v;
      v = 127.0 * x;
      return (v < 0.0) ? -int'($floor(0.5 - v)) : int'($floor(v + 0.5));
   endfunction

   function automatic logic [15:0] samp(input logic [1:0] md, input bit [31:0] acc_k,
                                        input int n_k, input int fpos, input int k);
      real th;
      int  re, im;
      re = 0;
      im = 0;
      case (md)
         2'd0: begin
            th = 2.0 * PI * real'(acc_k[31:22]) / 1024.0;
            re = rnd127($cos(th));
            im = rnd127($sin(th));
         end
         2'd1: begin
            re = n_k % 256;
            if (re > 127) re -= 256;
            im = -re - 1;
         end
         2'd2: if (k == 0 && fpos == 0) re = 127;
         default: ;
      endcase
      return {8'(re), 8'(im)};
   endfunction

   task automatic model_reset();
      m_vld = 0; m_last = 0; m_user = 0; m_pend = 0;
      m_dat = '0; m_acc = '0; m_n = 0; m_beat = 0;
      m1_vld = 0; m1_dat = '0; m1_n = 0;
   endtask

   task automatic model_edge();
      bit ld;
      int fpos;
      if (rst) begin
         model_reset();
         return;
      end
      ld = en && (!m_vld || rdy);
      if (ld) begin
         if (restart || m_pend) begin
            m_acc = '0; m_n = 0; m_beat = 0;
         end
         m_pend = 0;
         fpos   = m_beat % FL;
         for (int k = 0; k < SPC; k++)
            m_dat[k*16 +: 16] = samp(mode, m_acc + 32'(k) * phase_inc, m_n + k, fpos, k);
         m_last = (fpos == FL-1);
         m_user = (fpos == 0);
         m_vld  = 1;
         m_acc  = m_acc + 32'(SPC) * phase_inc;
         m_n   += SPC;
         m_beat++;
      end else begin
         if (restart) m_pend = 1;
         if (!en && rdy) m_vld = 0;
      end
      m1_vld = 1;
      m1_dat = samp(2'd1, '0, m1_n, 0, 0);
      m1_n++;
   endtask

   task automatic compare();
      logic [31:0] d;
      logic [15:0] d1;
      d  = ax.tdata;
      d1 = ax1.tdata;
      chk("tvalid", 64'(ax.tvalid), 64'(m_vld));
      if (m_vld) begin
         chk("tlast", 64'(ax.tlast), 64'(m_last));
         chk("tuser", 64'(ax.tuser[0]), 64'(m_user));
         chk("tdata", 64'(d), 64'(m_dat));
      end
      chk("f1_tvalid", 64'(ax1.tvalid), 64'(m1_vld));
      if (m1_vld) begin
         chk("f1_tlast", 64'(ax1.tlast), 64'd1);
         chk("f1_tuser", 64'(ax1.tuser[0]), 64'd1);
         chk("f1_tdata", 64'(d1), 64'(m1_dat));
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
   endtask

   function automatic logic [63:0] u8(input logic [7:0] v);
      return 64'(v);
   endfunction

   initial begin
      rst = 1; en = 0; mode = 0; phase_inc = 0; restart = 0; rdy = 0;
      en1 = 1; mode1 = 2'd1; pinc1 = 0; restart1 = 0;
      model_reset();
      repeat (2) cycle();
      chk("rst_tdata", 64'(ax.tdata), 64'd0);
      chk("rst_tlast", 64'(ax.tlast), 64'd0);
      chk("rst_tuser", 64'(ax.tuser[0]), 64'd0);
      rst = 0;
      cycle();

      // Quarter-turn tone: cos/sin walk through 127,0,-127,0
      mode = 2'd0; phase_inc = 32'h4000_0000; rdy = 1; en = 1;
      cycle();
      chk("tone_lat_vld", 64'(ax.tvalid), 64'd1);
      chk("tone_re0", u8(ax.tdata[0].re), u8(8'd127));
      chk("tone_re1", u8(ax.tdata[1].re), u8(8'd0));
      chk("tone_im1", u8(ax.tdata[1].im), u8(8'd127));
      cycle();
      chk("tone_re2", u8(ax.tdata[0].re), u8(8'h81));
      repeat (6) cycle();

      // Ramp long enough to wrap past 127
      mode = 2'd1; restart = 1;
      cycle();
      restart = 0;
      repeat (69) cycle();

      // Stall on beat 2 for three clocks
      restart = 1;
      cycle();
      restart = 0;
      repeat (2) cycle();
      rdy = 0;
      repeat (3) cycle();
      chk("stall_hold_re", u8(ax.tdata[0].re), u8(8'd4));
      rdy = 1;
      cycle();
      chk("stall_next_re", u8(ax.tdata[0].re), u8(8'd6));
      chk("stall_next_last", 64'(ax.tlast), 64'd1);

      // Two restarts during one stall at {10,11} merge into one
      restart = 1;
      cycle();
      restart = 0;
      repeat (5) cycle();
      rdy = 0; restart = 1;
      cycle();
      chk("rs_hold_re", u8(ax.tdata[0].re), u8(8'd10));
      restart = 0;
      cycle();
      restart = 1;
      cycle();
      restart = 0; rdy = 1;
      cycle();
      chk("rs_first_re", u8(ax.tdata[0].re), u8(8'd0));
      chk("rs_first_user", 64'(ax.tuser[0]), 64'd1);
      cycle();
      chk("rs_second_re", u8(ax.tdata[0].re), u8(8'd2));

      // Impulse over three frames
      mode = 2'd2; restart = 1;
      cycle();
      restart = 0;
      repeat (11) cycle();

      // Asynchronous reset between edges mid-frame
      mode = 2'd1; restart = 1;
      cycle();
      restart = 0;
      repeat (2) cycle();
      @(posedge clk);
      model_edge();
      #2 rst = 1;
      model_reset();
      #1;
      chk("arst_tvalid", 64'(ax.tvalid), 64'd0);
      chk("arst_tdata", 64'(ax.tdata), 64'd0);
      @(negedge clk);
      compare();
      cycle();
      rst = 0;
      cycle();
      chk("arst_first_re1", u8(ax.tdata[1].re), u8(8'd1));
      chk("arst_first_user", 64'(ax.tuser[0]), 64'd1);

      // Random traffic: enable gaps, backpressure, restarts, mode/phase changes
      for (int c = 0; c < 2500; c++) begin
         en      = ($urandom_range(0, 9) != 0);
         rdy     = ($urandom_range(0, 9) < 7);
         restart = ($urandom_range(0, 30) == 0);
         if ($urandom_range(0, 19) == 0) begin
            mode      = 2'($urandom_range(0, 3));
            phase_inc = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 1 << 24));
         end
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
